// File: rtl/cci_mpf_svc_vtp_client_mux.sv
// N-client front end to the shared VTP service: per-client 1-deep buffer, RR issue, tag-pool remap.
// Latency: client accept -> svc_lookupEn 2 cycles min; svc response -> client response 1 cycle.
// Backpressure: svc_lookupRdy holds the issue register; per-client limit and empty tag pool stall buffers.
module cci_mpf_svc_vtp_client_mux #(
    parameter int N_CLIENTS      = 4,
    parameter int VA_IDX_W       = 36,
    parameter int PA_IDX_W       = 36,
    parameter int CLI_TAG_W      = 4,
    parameter int MAX_REQS       = 16,
    parameter int MAX_PER_CLIENT = 8,
    localparam int SVC_TAG_W     = $clog2(MAX_REQS)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [N_CLIENTS-1:0]            cli_lookupEn,
    input  logic [N_CLIENTS*VA_IDX_W-1:0]   cli_lookupVA,
    input  logic [N_CLIENTS*CLI_TAG_W-1:0]  cli_lookupTag,
    output logic [N_CLIENTS-1:0]            cli_lookupRdy,
    output logic [N_CLIENTS-1:0]            cli_rspValid,
    output logic [PA_IDX_W-1:0]             cli_rspPA,
    output logic [CLI_TAG_W-1:0]            cli_rspTag,
    output logic                            cli_rspIsBigPage,
    output logic                            svc_lookupEn,
    output logic [VA_IDX_W-1:0]             svc_lookupVA,
    output logic [SVC_TAG_W-1:0]            svc_lookupTag,
    input  logic                            svc_lookupRdy,
    input  logic                            svc_rspValid,
    input  logic [PA_IDX_W-1:0]             svc_rspPA,
    input  logic [SVC_TAG_W-1:0]            svc_rspTag,
    input  logic                            svc_rspIsBigPage,
    output logic [SVC_TAG_W:0]              busy_cnt,
    output logic                            err_bad_tag
);

    localparam int CID_W  = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
    localparam int OCNT_W = $clog2(MAX_PER_CLIENT + 1);
    localparam int BUSY_W = SVC_TAG_W + 1;

    typedef struct packed {
        logic [CID_W-1:0]     cid;
        logic [CLI_TAG_W-1:0] ctag;
    } tag_ent_t;

    typedef struct packed {
        logic [VA_IDX_W-1:0]  va;
        logic [CLI_TAG_W-1:0] ctag;
    } req_t;

    logic [N_CLIENTS-1:0] buf_vld_q, buf_vld_d;
    req_t                 buf_q [N_CLIENTS];
    logic [MAX_REQS-1:0]  free_q, free_d;
    tag_ent_t             tag_tbl_q [MAX_REQS];
    logic [OCNT_W-1:0]    ocnt_q [N_CLIENTS];
    logic [OCNT_W-1:0]    ocnt_d [N_CLIENTS];
    logic [CID_W-1:0]     rr_q, rr_d;
    logic [BUSY_W-1:0]    busy_q, busy_d;
    logic                 err_q, err_d;

    logic                 out_vld_q, out_vld_d;
    logic [VA_IDX_W-1:0]  out_va_q, out_va_d;
    logic [SVC_TAG_W-1:0] out_tag_q, out_tag_d;

    logic [N_CLIENTS-1:0] rsp_vld_q, rsp_vld_d;
    logic [PA_IDX_W-1:0]  rsp_pa_q, rsp_pa_d;
    logic [CLI_TAG_W-1:0] rsp_tag_q, rsp_tag_d;
    logic                 rsp_big_q, rsp_big_d;

    logic [N_CLIENTS-1:0] elig;
    logic                 win_found;
    logic [CID_W-1:0]     win_id;
    logic                 free_found;
    logic [SVC_TAG_W-1:0] free_tag;
    logic                 load_ok, issue, rsp_ok, rsp_bad;
    tag_ent_t             rsp_ent;

    // A full buffer at its outstanding limit is not eligible, so it never blocks other clients.
    always_comb begin
        elig = '0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            elig[i] = buf_vld_q[i] && (ocnt_q[i] < OCNT_W'(MAX_PER_CLIENT));
        end
    end

    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int k = 0; k < N_CLIENTS; k++) begin
            if (!win_found && elig[(int'(rr_q) + k) % N_CLIENTS]) begin
                win_found = 1'b1;
                win_id    = CID_W'((int'(rr_q) + k) % N_CLIENTS);
            end
        end
    end

    // Uses the registered free vector, so a tag freed this cycle is only reusable next cycle.
    always_comb begin
        free_found = 1'b0;
        free_tag   = '0;
        for (int t = MAX_REQS - 1; t >= 0; t--) begin
            if (free_q[t]) begin
                free_found = 1'b1;
                free_tag   = SVC_TAG_W'(t);
            end
        end
    end

    assign load_ok = !out_vld_q || svc_lookupRdy;
    assign issue   = load_ok && free_found && win_found;
    assign rsp_ok  = svc_rspValid && !free_q[svc_rspTag];
    assign rsp_bad = svc_rspValid &&  free_q[svc_rspTag];
    assign rsp_ent = tag_tbl_q[svc_rspTag];

    always_comb begin
        buf_vld_d = buf_vld_q;
        for (int i = 0; i < N_CLIENTS; i++) begin
            if (cli_lookupEn[i] && !buf_vld_q[i]) begin
                buf_vld_d[i] = 1'b1;
            end
        end
        if (issue) begin
            buf_vld_d[win_id] = 1'b0;
        end

        free_d = free_q;
        if (issue) begin
            free_d[free_tag] = 1'b0;
        end
        if (rsp_ok) begin
            free_d[svc_rspTag] = 1'b1;
        end

        for (int i = 0; i < N_CLIENTS; i++) begin
            ocnt_d[i] = ocnt_q[i];
            if ((issue && (win_id == CID_W'(i))) && !(rsp_ok && (rsp_ent.cid == CID_W'(i)))) begin
                ocnt_d[i] = ocnt_q[i] + OCNT_W'(1);
            end else if (!(issue && (win_id == CID_W'(i))) && (rsp_ok && (rsp_ent.cid == CID_W'(i)))) begin
                ocnt_d[i] = ocnt_q[i] - OCNT_W'(1);
            end
        end

        busy_d = busy_q;
        if (issue && !rsp_ok) begin
            busy_d = busy_q + BUSY_W'(1);
        end else if (!issue && rsp_ok) begin
            busy_d = busy_q - BUSY_W'(1);
        end

        rr_d = rr_q;
        if (issue) begin
            rr_d = (win_id == CID_W'(N_CLIENTS - 1)) ? '0 : win_id + CID_W'(1);
        end

        out_vld_d = out_vld_q;
        out_va_d  = out_va_q;
        out_tag_d = out_tag_q;
        if (issue) begin
            out_vld_d = 1'b1;
            out_va_d  = buf_q[win_id].va;
            out_tag_d = free_tag;
        end else if (svc_lookupRdy) begin
            out_vld_d = 1'b0;
        end

        rsp_vld_d = '0;
        rsp_pa_d  = rsp_pa_q;
        rsp_tag_d = rsp_tag_q;
        rsp_big_d = rsp_big_q;
        if (rsp_ok) begin
            rsp_vld_d[rsp_ent.cid] = 1'b1;
            rsp_pa_d               = svc_rspPA;
            rsp_tag_d              = rsp_ent.ctag;
            rsp_big_d              = svc_rspIsBigPage;
        end

        err_d = err_q | rsp_bad;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_vld_q <= '0;
            free_q    <= '1;
            for (int i = 0; i < N_CLIENTS; i++) begin
                ocnt_q[i] <= '0;
            end
            rr_q      <= '0;
            busy_q    <= '0;
            err_q     <= 1'b0;
            out_vld_q <= 1'b0;
            out_va_q  <= '0;
            out_tag_q <= '0;
            rsp_vld_q <= '0;
            rsp_pa_q  <= '0;
            rsp_tag_q <= '0;
            rsp_big_q <= 1'b0;
        end else begin
            buf_vld_q <= buf_vld_d;
            free_q    <= free_d;
            for (int i = 0; i < N_CLIENTS; i++) begin
                ocnt_q[i] <= ocnt_d[i];
            end
            rr_q      <= rr_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
            out_vld_q <= out_vld_d;
            out_va_q  <= out_va_d;
            out_tag_q <= out_tag_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_pa_q  <= rsp_pa_d;
            rsp_tag_q <= rsp_tag_d;
            rsp_big_q <= rsp_big_d;
        end
    end

    // Payload storage is qualified by buf_vld_q / free_q, so it needs no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_CLIENTS; i++) begin
            if (cli_lookupEn[i] && !buf_vld_q[i]) begin
                buf_q[i].va   <= cli_lookupVA[i*VA_IDX_W +: VA_IDX_W];
                buf_q[i].ctag <= cli_lookupTag[i*CLI_TAG_W +: CLI_TAG_W];
            end
        end
        if (issue) begin
            tag_tbl_q[free_tag] <= {win_id, buf_q[win_id].ctag};
        end
    end

    assign cli_lookupRdy    = ~buf_vld_q;
    assign cli_rspValid     = rsp_vld_q;
    assign cli_rspPA        = rsp_pa_q;
    assign cli_rspTag       = rsp_tag_q;
    assign cli_rspIsBigPage = rsp_big_q;
    assign svc_lookupEn     = out_vld_q;
    assign svc_lookupVA     = out_va_q;
    assign svc_lookupTag    = out_tag_q;
    assign busy_cnt         = busy_q;
    assign err_bad_tag      = err_q;

    a_en_needs_rdy: assert property (@(posedge clk) disable iff (reset)
        (cli_lookupEn & ~cli_lookupRdy) == '0);

endmodule

// File: doc/cci_mpf_svc_vtp_client_mux.md
Name: cci_mpf_svc_vtp_client_mux

Overview:
N-client concurrent front end to the single shared VTP translation service. It buffers one lookup per client and arbitrates round-robin. Each issued lookup gets a globally unique service tag from a free pool, and out-of-order service responses are routed back to the originating client with that client's own tag restored. Per-client outstanding limits prevent one pipeline from starving the others. It sits between the VTP pipeline shims and the translation service / TLB.

Parameters:
N_CLIENTS, 4, number of client VTP pipelines (1..16)
VA_IDX_W, 36, 4KB virtual page index width
PA_IDX_W, 36, 4KB physical page index width
CLI_TAG_W, 4, client request tag width
MAX_REQS, 16, service tags in pool (power of 2); SVC_TAG_W = clog2(MAX_REQS)
MAX_PER_CLIENT, 8, outstanding limit per client (1..MAX_REQS)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
cli_lookupEn  in  N_CLIENTS  per-client request valid
cli_lookupVA  in  N_CLIENTS*VA_IDX_W  per-client page VA; client i at slice i
cli_lookupTag  in  N_CLIENTS*CLI_TAG_W  per-client tag
cli_lookupRdy  out  N_CLIENTS  client input buffer empty
cli_rspValid  out  N_CLIENTS  one-hot response strobe
cli_rspPA  out  PA_IDX_W  response PA (shared by all clients)
cli_rspTag  out  CLI_TAG_W  restored client tag
cli_rspIsBigPage  out  1  2MB translation
svc_lookupEn  out  1  service request valid
svc_lookupVA  out  VA_IDX_W  service request VA
svc_lookupTag  out  SVC_TAG_W  allocated service tag
svc_lookupRdy  in  1  service accepts request
svc_rspValid  in  1  service response strobe
svc_rspPA  in  PA_IDX_W  service response PA
svc_rspTag  in  SVC_TAG_W  service response tag
svc_rspIsBigPage  in  1  service response 2MB flag
busy_cnt  out  SVC_TAG_W+1  service tags currently allocated
err_bad_tag  out  1  sticky: response carried an unallocated tag

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset state:
  - All outputs 0, except cli_lookupRdy, which is all 1s.
  - Input buffers empty, all tags free, per-client counters 0, RR pointer 0, err_bad_tag 0.
  - Reset mid-operation discards all in-flight state. Responses arriving after reset are treated as bad tags.
- Client accept: cli_lookupRdy[i] is registered and equals "buffer i empty"; it does not depend on cli_lookupEn. When cli_lookupEn[i] && cli_lookupRdy[i], {VA, tag} is captured and the buffer is full next cycle. cli_lookupEn with Rdy low is a protocol error (ignored; sim assertion).
- Issue: the output register is loadable when it is empty or svc_lookupRdy=1 this cycle. It loads only if all of the following hold:
  - a free tag exists;
  - some buffer i is full with outstanding[i] < MAX_PER_CLIENT.
- Arbitration:
  - Winner is the first eligible client at or after the RR pointer, wrapping modulo N_CLIENTS.
  - Pointer becomes winner+1 (wrapping) on issue only.
  - A full buffer that is blocked by its limit is skipped; it does not block others.
- Tag allocation: lowest-index free tag from the registered free vector. The tag table entry is written with {client id, client tag}. The winner's buffer empties, so cli_lookupRdy rises next cycle.
- Service handshake:
  - svc_lookupEn/VA/Tag are registered and held stable until svc_lookupRdy=1.
  - Minimum latency from client accept to svc_lookupEn is 2 cycles.
- Response path:
  - When svc_rspValid and the tag is allocated, the next cycle drives cli_rspValid[client]=1 (one-hot) with PA, IsBigPage and the restored client tag. That tag is freed and outstanding[client] is decremented.
  - Response latency is exactly 1 cycle. There is no back-pressure; clients must always accept.
  - cli_rspPA, cli_rspTag and cli_rspIsBigPage are don't-care when cli_rspValid=0.
- Bad tag: svc_rspValid with an unallocated tag drops the response, sets err_bad_tag (cleared only by reset) and leaves state unchanged.
- Simultaneous events:
  - Free and allocate in the same cycle: the freed tag is not reusable until the next cycle (allocation uses the pre-free vector).
  - Same-client issue and response in one cycle: outstanding[i] unchanged.
  - busy_cnt uses the same rule: +1 on allocate, -1 on valid free, net 0 when both occur.
- Full conditions:
  - busy_cnt==MAX_REQS: no issue; buffers stay full and Rdy stays low.
  - Outstanding counters saturate by construction, never exceeding MAX_PER_CLIENT.

Test Plan:
1. Reset, then client 0 sends VA=0x123, tag=5 at cycle 1 -> svc_lookupEn at cycle 3 with svc_lookupTag=0. Service responds tag 0, PA=0xABC, IsBigPage=1 -> next cycle cli_rspValid=4'b0001, cli_rspTag=5, PA=0xABC, busy_cnt back to 0.
2. All 4 clients request in the same cycle, svc_lookupRdy=1 -> issue order 0,1,2,3 on consecutive cycles with tags 0,1,2,3. A second wave issues in order 0,1,2,3 (RR pointer wrapped).
3. Client 2 streams 12 requests with no responses -> exactly 8 issue, then cli_lookupRdy[2] stays 0. Client 1 request still issues. One response to client 2 lets its 9th issue.
4. Fill all 16 tags, respond to tag 7 while a buffered request waits -> new issue gets tag 7 exactly one cycle after the response, never in the same cycle.
5. Responses out of order (tags 3,0,2,1 from clients 3,0,2,1) -> each is routed to the correct one-hot client with its original tag. svc_rspTag=9 while unallocated -> no cli_rspValid, err_bad_tag=1.
6. Hold svc_lookupRdy=0 for 5 cycles -> svc outputs stable and further issue blocked. Assert reset mid-stream -> all outputs cleared immediately (async), busy_cnt=0, cli_lookupRdy=4'b1111.
